gcd_requester: RTL

- Initiator for the GCD engine's 4-phase req/ack load protocol.
- Accepts an operand pair on a valid/ready input stream and presents operand A, then operand B, each under its own full req/ack handshake.
- Captures the GCD result during the second handshake and returns it on a valid/ready output stream, with an error flag and a latency count.
- Sits between a host/stream producer and the GCD engine; both blocks share clock and reset.

---
 rtl/gcd_requester.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/gcd_requester.sv
// gcd_requester: takes an operand pair from a valid/ready stream and loads it
// into the GCD engine over two 4-phase req/ack handshakes (A, then B). It
// captures the engine result during the B handshake and returns it on a
// valid/ready stream with an error flag and an accept-to-valid cycle count.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | ready for a new pair; zero operands go straight to DONE w/ error
// REQ_A  | req high, loadVal=A, waiting for ack
// REL_A  | req low, loadVal=B, waiting for ack to fall
// REQ_B  | req high, loadVal=B, engine computing until ack
// REL_B  | req low, result captured, waiting for ack to fall
// DONE   | out_valid high, outputs frozen until out_ready
module gcd_requester #(
  parameter int W  = 128,
  parameter int CW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_result,
  output logic          out_error,
  output logic [CW-1:0] out_cycles,
  output logic          req,
  input  logic          ack,
  output logic [W-1:0]  loadVal,
  input  logic [W-1:0]  result
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ_A = 3'd1,
    REL_A = 3'd2,
    REQ_B = 3'd3,
    REL_B = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t        r_state;
  logic [W-1:0]  r_b;
  logic          r_req;
  logic [W-1:0]  r_load;
  logic          r_out_valid;
  logic [W-1:0]  r_out_result;
  logic          r_out_error;
  logic [CW-1:0] r_cnt;

  state_t        w_state_nxt;
  logic [W-1:0]  w_b_nxt;
  logic          w_req_nxt;
  logic [W-1:0]  w_load_nxt;
  logic          w_out_valid_nxt;
  logic [W-1:0]  w_out_result_nxt;
  logic          w_out_error_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_cnt_inc;
  logic          w_zero_op;

  // Saturating increment; the counter simply stops at all-ones.
  assign w_cnt_inc = (r_cnt == {CW{1'b1}}) ? r_cnt : r_cnt + CW'(1);
  assign w_zero_op = (in_a == '0) || (in_b == '0);

  // State and registered-output update, synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_b          <= '0;
      r_req        <= 1'b0;
      r_load       <= '0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_error  <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_b          <= w_b_nxt;
      r_req        <= w_req_nxt;
      r_load       <= w_load_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_out_result <= w_out_result_nxt;
      r_out_error  <= w_out_error_nxt;
      r_cnt        <= w_cnt_nxt;
    end
  end

  // Next-state and next-output decode; everything holds unless a transition fires.
  always_comb begin
    w_state_nxt      = r_state;
    w_b_nxt          = r_b;
    w_req_nxt        = r_req;
    w_load_nxt       = r_load;
    w_out_valid_nxt  = r_out_valid;
    w_out_result_nxt = r_out_result;
    w_out_error_nxt  = r_out_error;
    w_cnt_nxt        = r_cnt;

    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_b_nxt   = in_b;
          w_cnt_nxt = CW'(1);
          if (w_zero_op) begin
            // The engine would never finish on a zero operand, so skip it.
            w_state_nxt      = DONE;
            w_out_valid_nxt  = 1'b1;
            w_out_error_nxt  = 1'b1;
            w_out_result_nxt = '0;
          end else begin
            w_state_nxt = REQ_A;
            w_req_nxt   = 1'b1;
            w_load_nxt  = in_a;
          end
        end
      end
      REQ_A: begin
        w_cnt_nxt = w_cnt_inc;
        if (ack) begin
          w_req_nxt   = 1'b0;
          w_load_nxt  = r_b;
          w_state_nxt = REL_A;
        end
      end
      REL_A: begin
        w_cnt_nxt = w_cnt_inc;
        if (!ack) begin
          w_req_nxt   = 1'b1;
          w_state_nxt = REQ_B;
        end
      end
      REQ_B: begin
        w_cnt_nxt = w_cnt_inc;
        if (ack) begin
          w_out_result_nxt = result;
          w_req_nxt        = 1'b0;
          w_state_nxt      = REL_B;
        end
      end
      REL_B: begin
        w_cnt_nxt = w_cnt_inc;
        if (!ack) begin
          w_out_valid_nxt = 1'b1;
          w_out_error_nxt = 1'b0;
          w_state_nxt     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_req_nxt   = 1'b0;
      end
    endcase
  end

  assign in_ready   = (r_state == IDLE);
  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_error  = r_out_error;
  assign out_cycles = r_cnt;
  assign req        = r_req;
  assign loadVal    = r_load;

endmodule
